// File: rtl/serial_link_credit_sync.sv
// Credit-based flow-control stage for one virtual channel of the serial-link NoC bridge.
// Define SERIAL_LINK_CREDIT_SYNC_ASSERT_EN to compile in the protocol checker.

`ifdef SERIAL_LINK_CREDIT_SYNC_ASSERT_EN
module serial_link_credit_sync_checker #(
  parameter int NumCredits  = 8,
  parameter int CreditWidth = $clog2(NumCredits + 1)
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  input logic [CreditWidth-1:0] avail_i,
  input logic [CreditWidth:0]   inc_i,
  input logic                   data_acc_i,
  input logic                   req_cred_i,
  input logic                   send_valid_o_i,
  input logic                   send_ready_i_i,
  input logic                   credits_only_i
);

  // Returned credits must never push the pool beyond the remote buffer depth.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ({1'b0, avail_i} + inc_i) <= (CreditWidth + 1)'(NumCredits));

  // A credit-consuming data beat must never go out with an empty pool.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(data_acc_i && req_cred_i && (avail_i == '0)));

  // A stalled downstream beat stays presented and keeps its kind.
  a_hold_beat: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (send_valid_o_i && !send_ready_i_i) |=> (send_valid_o_i && $stable(credits_only_i)));

endmodule
`endif

module serial_link_credit_sync #(
  parameter int DataWidth        = 32,
  parameter int NumCredits       = 8,
  parameter int CreditWidth      = $clog2(NumCredits + 1),
  parameter int ForceSendThresh  = NumCredits - 4,
  parameter bit CredOnlyConsCred = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DataWidth-1:0]   data_to_send_i,
  input  logic                   send_valid_i,
  output logic                   send_ready_o,
  output logic [DataWidth-1:0]   data_to_send_o,
  output logic                   send_valid_o,
  input  logic                   send_ready_i,
  output logic                   credits_only_packet_o,
  output logic [CreditWidth-1:0] credits_to_send_o,
  input  logic                   req_cred_to_buffer_msg,
  input  logic [CreditWidth-1:0] credits_received_i,
  input  logic                   receive_cred_i,
  input  logic                   buffer_queue_out_val_i,
  input  logic                   buffer_queue_out_rdy_i,
  input  logic                   allow_cred_consume_i,
  input  logic                   consume_cred_to_send_i
);

  localparam int                   SumWidth  = CreditWidth + 1;
  localparam logic [SumWidth-1:0]  MaxSum    = SumWidth'(NumCredits);
  localparam logic [CreditWidth-1:0] Thresh  = CreditWidth'(ForceSendThresh);

  logic [CreditWidth-1:0] avail_q, avail_d;
  logic [CreditWidth-1:0] owed_q, owed_d;
  logic                   pending_q, pending_d;

  logic                   credit_ok_s;
  logic                   data_valid_s;
  logic                   force_s;
  logic                   cred_only_s;
  logic                   data_acc_s;
  logic                   cred_acc_s;
  logic                   dec_s;
  logic [SumWidth-1:0]    inc_s;
  logic [SumWidth-1:0]    avail_sum_s;
  logic [SumWidth-1:0]    owed_sum_s;

  // Beat selection, handshake outputs and next-state computation.
  always_comb begin
    credit_ok_s  = !req_cred_to_buffer_msg || (avail_q != '0);
    data_valid_s = send_valid_i && credit_ok_s;
    force_s      = allow_cred_consume_i && (owed_q >= Thresh) &&
                   (!CredOnlyConsCred || (avail_q != '0));
    // A held credit-only beat wins over anything newly offered.
    cred_only_s  = pending_q || (force_s && !data_valid_s);

    data_to_send_o        = data_to_send_i;
    credits_only_packet_o = cred_only_s;
    if (cred_only_s) begin
      send_valid_o = 1'b1;
      send_ready_o = 1'b0;
    end else begin
      send_valid_o = data_valid_s;
      send_ready_o = send_ready_i && credit_ok_s;
    end

    data_acc_s = !cred_only_s && data_valid_s && send_ready_i;
    cred_acc_s = cred_only_s && send_ready_i;
    dec_s      = (data_acc_s && req_cred_to_buffer_msg) || (cred_acc_s && CredOnlyConsCred);
    inc_s      = receive_cred_i ? {1'b0, credits_received_i} : '0;

    // Wide sum so a simultaneous return and consume never wraps before saturation.
    avail_sum_s = {1'b0, avail_q} + inc_s - {{(SumWidth-1){1'b0}}, dec_s};
    if (avail_sum_s > MaxSum) begin
      avail_d = CreditWidth'(NumCredits);
    end else begin
      avail_d = avail_sum_s[CreditWidth-1:0];
    end

    owed_sum_s = (consume_cred_to_send_i ? '0 : {1'b0, owed_q}) +
                 {{(SumWidth-1){1'b0}}, (buffer_queue_out_val_i && buffer_queue_out_rdy_i)};
    if (owed_sum_s > MaxSum) begin
      owed_d = CreditWidth'(NumCredits);
    end else begin
      owed_d = owed_sum_s[CreditWidth-1:0];
    end

    pending_d = cred_only_s && !send_ready_i;
  end

  // Credit pools and the held credit-only beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      avail_q   <= CreditWidth'(NumCredits);
      owed_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      avail_q   <= avail_d;
      owed_q    <= owed_d;
      pending_q <= pending_d;
    end
  end

  assign credits_to_send_o = owed_q;

`ifdef SERIAL_LINK_CREDIT_SYNC_ASSERT_EN
  serial_link_credit_sync_checker #(
    .NumCredits (NumCredits),
    .CreditWidth(CreditWidth)
  ) u_checker (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .avail_i       (avail_q),
    .inc_i         (inc_s),
    .data_acc_i    (data_acc_s),
    .req_cred_i    (req_cred_to_buffer_msg),
    .send_valid_o_i(send_valid_o),
    .send_ready_i_i(send_ready_i),
    .credits_only_i(credits_only_packet_o)
  );
`endif

endmodule

// File: tb/tb_serial_link_credit_sync.sv
// Self-checking bench for serial_link_credit_sync: directed scenarios plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_serial_link_credit_sync;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);
  localparam int TH = N - 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [DW-1:0] data_to_send_i;
  logic          send_valid_i;
  logic          send_ready_o;
  logic [DW-1:0] data_to_send_o;
  logic          send_valid_o;
  logic          send_ready_i;
  logic          credits_only_packet_o;
  logic [CW-1:0] credits_to_send_o;
  logic          req_cred_to_buffer_msg;
  logic [CW-1:0] credits_received_i;
  logic          receive_cred_i;
  logic          buffer_queue_out_val_i;
  logic          buffer_queue_out_rdy_i;
  logic          allow_cred_consume_i;
  logic          consume_cred_to_send_i;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  // Model state: remote credits, owed credits, stalled credit-only beat.
  int m_avail;
  int m_owed;
  bit m_pend;
  bit m_stall_data;

  serial_link_credit_sync #(.DataWidth(DW), .NumCredits(N)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .data_to_send_i        (data_to_send_i),
    .send_valid_i          (send_valid_i),
    .send_ready_o          (send_ready_o),
    .data_to_send_o        (data_to_send_o),
    .send_valid_o          (send_valid_o),
    .send_ready_i          (send_ready_i),
    .credits_only_packet_o (credits_only_packet_o),
    .credits_to_send_o     (credits_to_send_o),
    .req_cred_to_buffer_msg(req_cred_to_buffer_msg),
    .credits_received_i    (credits_received_i),
    .receive_cred_i        (receive_cred_i),
    .buffer_queue_out_val_i(buffer_queue_out_val_i),
    .buffer_queue_out_rdy_i(buffer_queue_out_rdy_i),
    .allow_cred_consume_i  (allow_cred_consume_i),
    .consume_cred_to_send_i(consume_cred_to_send_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle_inputs();
    data_to_send_i         = '0;
    send_valid_i           = 1'b0;
    send_ready_i           = 1'b0;
    req_cred_to_buffer_msg = 1'b1;
    credits_received_i     = '0;
    receive_cred_i         = 1'b0;
    buffer_queue_out_val_i = 1'b0;
    buffer_queue_out_rdy_i = 1'b0;
    allow_cred_consume_i   = 1'b0;
    consume_cred_to_send_i = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; checks and advances one cycle.
  task automatic step(input string tag);
    bit cok, dv, frc, co, exp_valid, exp_ready, acc_d, acc_c;
    int na, no;
    #3;
    cok = !req_cred_to_buffer_msg || (m_avail > 0);
    dv  = send_valid_i && cok;
    frc = allow_cred_consume_i && (m_owed >= TH);
    co  = m_pend || (frc && !dv);
    exp_valid = co ? 1'b1 : dv;
    exp_ready = co ? 1'b0 : (send_ready_i && cok);
    check_eq({tag, "_valid"}, 32'(send_valid_o), 32'(exp_valid));
    check_eq({tag, "_ready"}, 32'(send_ready_o), 32'(exp_ready));
    check_eq({tag, "_credonly"}, 32'(credits_only_packet_o), 32'(co));
    check_eq({tag, "_owed"}, 32'(credits_to_send_o), 32'(m_owed));
    check_eq({tag, "_data"}, data_to_send_o, data_to_send_i);
    if (send_valid_o && send_ready_i && !credits_only_packet_o) acc_cnt++;

    acc_d = !co && dv && send_ready_i;
    acc_c = co && send_ready_i;
    na = m_avail - ((acc_d && req_cred_to_buffer_msg) ? 1 : 0)
                 + (receive_cred_i ? int'(credits_received_i) : 0);
    if (na > N) na = N;
    no = (consume_cred_to_send_i ? 0 : m_owed) +
         ((buffer_queue_out_val_i && buffer_queue_out_rdy_i) ? 1 : 0);
    if (no > N) no = N;
    @(posedge clk_i);
    #1;
    m_avail      = na;
    m_owed       = no;
    m_pend       = co && !send_ready_i;
    m_stall_data = !co && exp_valid && !send_ready_i;
  endtask

  task automatic model_reset();
    m_avail      = N;
    m_owed       = 0;
    m_pend       = 1'b0;
    m_stall_data = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_valid", 32'(send_valid_o), 32'd0);
    check_eq("rst_credonly", 32'(credits_only_packet_o), 32'd0);
    check_eq("rst_owed", 32'(credits_to_send_o), 32'd0);
    rst_ni = 1'b1;

    // Exhaust the 8 remote credits with a continuous stream.
    send_valid_i = 1'b1; send_ready_i = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      data_to_send_i = $urandom;
      step("burst");
    end
    check_eq("burst_accepted", 32'(acc_cnt), 32'd8);

    // Return three credits, then exactly three more beats go out.
    send_valid_i = 1'b0; receive_cred_i = 1'b1; credits_received_i = CW'(3);
    step("ret3");
    receive_cred_i = 1'b0; credits_received_i = '0; send_valid_i = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      data_to_send_i = $urandom;
      step("after_ret");
    end
    check_eq("after_ret_accepted", 32'(acc_cnt), 32'd3);

    // Four dequeues raise a credit-only beat that survives a stall.
    send_valid_i = 1'b0; send_ready_i = 1'b0; allow_cred_consume_i = 1'b1;
    buffer_queue_out_val_i = 1'b1; buffer_queue_out_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) step("deq");
    buffer_queue_out_val_i = 1'b0;
    check_eq("deq_owed", 32'(credits_to_send_o), 32'd4);
    step("co_stall0");
    allow_cred_consume_i = 1'b0;
    for (int i = 0; i < 3; i++) step("co_stall");
    send_ready_i = 1'b1; consume_cred_to_send_i = 1'b1;
    step("co_accept");
    consume_cred_to_send_i = 1'b0;
    check_eq("co_owed_cleared", 32'(credits_to_send_o), 32'd0);
    check_eq("co_gone", 32'(send_valid_o), 32'd0);

    // Clear and dequeue together at owed=5 leaves one owed credit.
    buffer_queue_out_val_i = 1'b1;
    for (int i = 0; i < 5; i++) step("owed5");
    consume_cred_to_send_i = 1'b1;
    step("clr_inc");
    consume_cred_to_send_i = 1'b0; buffer_queue_out_val_i = 1'b0;
    check_eq("clr_inc_owed", 32'(credits_to_send_o), 32'd1);

    // At avail=4 a consumed and a returned credit cancel out.
    receive_cred_i = 1'b1; credits_received_i = CW'(4);
    step("fill4");
    send_valid_i = 1'b1; credits_received_i = CW'(1);
    step("inc_dec");
    receive_cred_i = 1'b0; credits_received_i = '0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) step("drain4");
    check_eq("drain4_accepted", 32'(acc_cnt), 32'd4);

    // With credit checking off, data flows at avail=0 without touching avail.
    req_cred_to_buffer_msg = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      data_to_send_i = $urandom;
      step("bypass");
    end
    check_eq("bypass_accepted", 32'(acc_cnt), 32'd8);
    req_cred_to_buffer_msg = 1'b1;
    step("bypass_off");

    // Asynchronous reset in the middle of a stalled credit-only beat.
    send_valid_i = 1'b0; send_ready_i = 1'b0; buffer_queue_out_val_i = 1'b1;
    for (int i = 0; i < 4; i++) step("pre_rst");
    buffer_queue_out_val_i = 1'b0; allow_cred_consume_i = 1'b1;
    step("pend_set");
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_valid", 32'(send_valid_o), 32'd0);
    check_eq("midrst_credonly", 32'(credits_only_packet_o), 32'd0);
    check_eq("midrst_owed", 32'(credits_to_send_o), 32'd0);
    idle_inputs();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (!m_stall_data) begin
        send_valid_i   = ($urandom_range(3, 0) != 0);
        data_to_send_i = $urandom;
      end
      send_ready_i           = ($urandom_range(2, 0) != 0);
      req_cred_to_buffer_msg = ($urandom_range(7, 0) != 0);
      receive_cred_i         = ($urandom_range(3, 0) == 0);
      credits_received_i     = receive_cred_i ? CW'($urandom_range(N - m_avail, 0)) : '0;
      buffer_queue_out_val_i = $urandom_range(1, 0);
      buffer_queue_out_rdy_i = $urandom_range(1, 0);
      allow_cred_consume_i   = $urandom_range(1, 0);
      consume_cred_to_send_i = ($urandom_range(5, 0) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_link_credit_sync.md
Name: serial_link_credit_sync

Overview:
- Credit-based flow-control stage for one virtual channel of the serial-link NoC bridge.
- Gates outgoing data flits on available remote credits.
- Counts local buffer dequeues as credits owed to the remote side and reports them for piggybacking.
- When owed credits reach a threshold and no data is available, emits a credit-only packet.

Parameters:
- DataWidth, 32: flit payload width.
- NumCredits, 8: remote buffer depth; reset value of available credits.
- CreditWidth, $clog2(NumCredits+1): width of all credit counters and ports.
- ForceSendThresh, NumCredits-4: owed-credit count at or above which a credit-only packet is requested.
- CredOnlyConsCred, 0: 1 means a credit-only packet consumes one available credit.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- data_to_send_i  in  DataWidth  upstream flit.
- send_valid_i  in  1  upstream valid.
- send_ready_o  out  1  upstream ready.
- data_to_send_o  out  DataWidth  downstream flit; combinational copy of data_to_send_i.
- send_valid_o  out  1  downstream valid (data or credit-only).
- send_ready_i  in  1  downstream ready.
- credits_only_packet_o  out  1  current downstream beat carries no valid data.
- credits_to_send_o  out  CreditWidth  owed-credit counter value.
- req_cred_to_buffer_msg  in  1  1 means data flits need and consume credits; 0 means data bypasses credit check.
- credits_received_i  in  CreditWidth  credits returned by remote.
- receive_cred_i  in  1  add credits_received_i this cycle.
- buffer_queue_out_val_i  in  1  local receive queue valid.
- buffer_queue_out_rdy_i  in  1  local receive queue ready; val&rdy adds 1 owed credit.
- allow_cred_consume_i  in  1  this channel's credits are currently selected for piggybacking.
- consume_cred_to_send_i  in  1  owed credits were transmitted this cycle; clear counter.

Behaviour:
- Reset values:
  - avail = NumCredits; owed = 0; pending = 0.
  - send_valid_o = 0, credits_only_packet_o = 0, credits_to_send_o = 0.
  - send_ready_o = send_ready_i & credit_ok (combinational).
- credit_ok = ~req_cred_to_buffer_msg | (avail != 0).
- Data path is fully combinational, zero latency.
- Data beat (pending = 0):
  - send_valid_o = send_valid_i & credit_ok.
  - send_ready_o = send_ready_i & credit_ok.
  - credits_only_packet_o = 0.
- Force condition: force = allow_cred_consume_i & (owed >= ForceSendThresh) & (CredOnlyConsCred == 0 | avail != 0).
- Credit-only beat:
  - Occurs when force holds and (send_valid_i & credit_ok) is 0, or when pending = 1.
  - Outputs: send_valid_o = 1, credits_only_packet_o = 1, send_ready_o = 0.
  - If not accepted (~send_ready_i), pending is set. While pending, the beat is held regardless of allow_cred_consume_i or send_valid_i. pending clears on send_ready_i.
- avail update, next = avail − dec + inc:
  - dec = 1 on an accepted data beat when req_cred_to_buffer_msg = 1.
  - dec = 1 on an accepted credit-only beat when CredOnlyConsCred = 1.
  - inc = credits_received_i when receive_cred_i.
  - Simultaneous dec and inc are both applied in the same cycle.
- owed update:
  - next = (consume_cred_to_send_i ? 0 : owed) + (buffer_queue_out_val_i & buffer_queue_out_rdy_i).
  - Clear and increment in the same cycle gives 1.
  - owed saturates at NumCredits.
- credits_to_send_o = owed (registered value).
- Overflow rule: avail must never exceed NumCredits; it saturates at NumCredits.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; any pending beat is dropped.

Optional Feature:
- Macro SERIAL_LINK_CREDIT_SYNC_ASSERT_EN.
- Defined: concurrent assertions are compiled in:
  - avail + inc never exceeds NumCredits.
  - No accepted data beat with req_cred_to_buffer_msg = 1 while avail = 0.
  - send_valid_o & ~send_ready_i |=> send_valid_o stays high and credits_only_packet_o is stable.
- Undefined: no assertions; functionally identical.

Test Plan:
- Reset, then send_valid_i=1 and send_ready_i=1 for 10 cycles (NumCredits=8, req_cred_to_buffer_msg=1) -> exactly 8 accepted beats; avail=0; send_ready_o=0 from cycle 9.
- avail=0, receive_cred_i=1 with credits_received_i=3 -> avail=3 next cycle; 3 more beats accepted.
- 4 local dequeues with allow_cred_consume_i=1 and send_valid_i=0 -> credits_to_send_o=4; send_valid_o=1 with credits_only_packet_o=1; hold send_ready_i=0 for 3 cycles, dropping allow_cred_consume_i -> beat stays valid; accept with consume_cred_to_send_i=1 -> owed=0, avail unchanged (CredOnlyConsCred=0).
- owed=5 with consume_cred_to_send_i and a dequeue in the same cycle -> owed=1.
- Accepted data beat plus receive_cred_i (credits_received_i=1) in the same cycle at avail=4 -> avail=4.
- req_cred_to_buffer_msg=0, avail forced to 0 via 8 sends -> data still accepted; avail stays 0.
